add_serial_param: RTL and testbench

ADD_SERIAL_PARAM -- requirements
Module: add_serial_param

---
 rtl/add_serial_pkg.sv | 24 ++
 rtl/add_serial_digit.sv | 18 +
 rtl/add_serial_param.sv | 113 +++++++++++
 tb/tb_add_serial_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/add_serial_pkg.sv
// Shared types and sizing helper for the digit-serial adder/subtractor.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] cnt_w;
  } add_serial_cfg_t;

  // Number of digit steps and the counter width able to hold that step count.
  function automatic add_serial_cfg_t add_serial_cfg(input int unsigned width,
                                                     input int unsigned digit);
    add_serial_cfg_t c;
    c.n     = (digit == 0) ? 32'd1 : 32'(width / digit);
    c.cnt_w = 32'($clog2(c.n + 32'd1));
    return c;
  endfunction

endpackage

// File: rtl/add_serial_digit.sv
// DIGIT-bit ripple adder slice used once per cycle by the serial engine.
module add_serial_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] sum_c;

  assign sum_c = (DIGIT+1)'(x) + (DIGIT+1)'(y) + (DIGIT+1)'(cin);
  assign s     = sum_c[DIGIT-1:0];
  assign co    = sum_c[DIGIT];

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle.
// Subtraction support is built only when ADD_SERIAL_SUB_EN is defined.
module add_serial_param
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam add_serial_cfg_t CFG = add_serial_cfg(WIDTH, DIGIT);
  localparam int unsigned N  = CFG.n;
  localparam int unsigned CW = CFG.cnt_w;

  if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("add_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, cout_q, done_q, busy_q;

  logic [WIDTH-1:0] b_in_c;
  logic             sub_eff_c;
  logic [DIGIT-1:0] dsum_c;
  logic             dco_c;

`ifdef ADD_SERIAL_SUB_EN
  assign sub_eff_c = sub;
  assign b_in_c    = sub ? ~b : b;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff_c  = 1'b0;
  assign b_in_c     = b;
`endif

  add_serial_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .cin(carry_q),
    .s  (dsum_c),
    .co (dco_c)
  );

  // Control FSM and datapath; the result assembles LSB-first from the top of out_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            a_q     <= a;
            b_q     <= b_in_c;
            out_q   <= '0;
            count_q <= '0;
            carry_q <= sub_eff_c;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          out_q   <= (out_q >> DIGIT) | (WIDTH'(dsum_c) << (WIDTH - DIGIT));
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dco_c;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            cout_q  <= dco_c;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_add_serial_param.sv
// Bench for add_serial_param: 8x1 and 16x4 instances against an arithmetic model.
module tb_add_serial_param;

`ifdef ADD_SERIAL_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic        clk, rst;
  logic        en8, sub8, busy8, done8, cout8;
  logic [7:0]  a8, b8, out8;
  logic        en16, sub16, busy16, done16, cout16;
  logic [15:0] a16, b16, out16;

  int tests = 0;
  int fails = 0;

  add_serial_param #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .out(out8), .cout(cout8)
  );

  add_serial_param #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16), .sub(sub16),
    .busy(busy16), .done(done16), .out(out16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry, result} of a w-bit add or (if enabled) two's-complement subtract.
  function automatic logic [16:0] ref_model(input bit w16, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
    int unsigned w = w16 ? 16 : 8;
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned av = 64'(a) & mask;
    longint unsigned bv = 64'(b) & mask;
    longint unsigned full;
    if (s && SUB_ON) full = av + ((~bv) & mask) + 64'd1;
    else             full = av + bv;
    return {1'(full >> w), 16'(full & mask)};
  endfunction

  // One full operation: start, scramble inputs, time done, check result and idle return.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] eo, input logic ec,
                        input string tag);
    int n = w16 ? 4 : 8;
    int cyc;
    int bcnt;
    @(negedge clk);
    if (w16) begin a16 = a; b16 = b; sub16 = s; en16 = 1'b1; end
    else     begin a8 = a[7:0]; b8 = b[7:0]; sub8 = s; en8 = 1'b1; end
    @(negedge clk);
    en8 = 1'b0; en16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    cyc = 1; bcnt = 0;
    while (cyc < 40) begin
      if (w16 ? busy16 : busy8) bcnt++;
      if (w16 ? done16 : done8) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(n + 1));
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(n + 1));
    chk({tag, ".out"}, 32'(w16 ? out16 : {8'h0, out8}), 32'(eo));
    chk({tag, ".cout"}, 32'(w16 ? cout16 : cout8), 32'(ec));
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(w16 ? busy16 : busy8), 32'd0);
    chk({tag, ".hold_out"}, 32'(w16 ? out16 : {8'h0, out8}), 32'(eo));
  endtask

  initial begin
    logic [16:0] m;
    logic [15:0] ra, rb;
    logic        rs;
    bit          w;
    int          cyc, cnt;

    rst = 1'b1; en8 = 1'b0; en16 = 1'b0;
    a8 = '0; b8 = '0; sub8 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.busy8", 32'(busy8), 32'd0);
    chk("reset.done8", 32'(done8), 32'd0);
    chk("reset.out8", 32'(out8), 32'd0);
    chk("reset.cout8", 32'(cout8), 32'd0);
    chk("reset.out16", 32'(out16), 32'd0);
    chk("reset.busy16", 32'(busy16), 32'd0);

    run_op(1'b0, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, "add_5a_33");
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_ff_01");
    run_op(1'b1, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, "add16_wrap");
    if (SUB_ON) begin
      run_op(1'b0, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, "sub_10_01");
      run_op(1'b0, 16'h0001, 16'h0002, 1'b1, 16'h00FF, 1'b0, "sub_01_02");
    end else begin
      run_op(1'b0, 16'h0010, 16'h0001, 1'b1, 16'h0011, 1'b0, "sub_ignored");
    end

    // en re-pulsed mid-operation must be ignored and not queued
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    repeat (2) @(negedge clk);
    en8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    en8 = 1'b0;
    cyc = 4;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("reen.latency", 32'(cyc), 32'd9);
    chk("reen.out", 32'(out8), 32'h8D);
    chk("reen.cout", 32'(cout8), 32'd0);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (busy8) cnt++; end
    chk("reen.no_second_op", 32'(cnt), 32'd0);

    // reset during ADD aborts without a done pulse
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(busy8), 32'd0);
    chk("abort.out", 32'(out8), 32'd0);
    chk("abort.cout", 32'(cout8), 32'd0);
    chk("abort.done", 32'(done8), 32'd0);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) cnt++; end
    chk("abort.no_done", 32'(cnt), 32'd0);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; en8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    rst = 1'b0; en8 = 1'b0;
    chk("rst_en.busy", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("rst_en.busy_next", 32'(busy8), 32'd0);

    for (int i = 0; i < 24; i++) begin
      w  = (i % 2) == 1;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (!w) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
      m = ref_model(w, ra, rb, rs);
      run_op(w, ra, rb, rs, m[15:0], m[16], w ? "rand16" : "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
